// File: rtl/tb_service_pkg.sv
// Shared types and defaults for the TB service command dispatcher.
// Holds the FSM state encoding, the default service address and the long-hold command.
package tb_service_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [31:0] SERVICE_ADDR_DEFAULT = 32'h2100_0410;
    localparam logic [7:0]  LONG_CMD_VALUE       = 8'h10;

    // A write is a service command only at the service address with a non-zero command byte.
    function automatic logic is_service_write(input logic        valid,
                                              input logic [31:0] addr,
                                              input logic [31:0] data,
                                              input logic [31:0] svc_addr);
        return valid && (addr == svc_addr) && (data[7:0] != 8'h00);
    endfunction

endpackage

// File: rtl/tb_service_cmd_dispatch_if.sv
// Write-strobe bus feeding the TB service command dispatcher.
interface tb_service_cmd_dispatch_if;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface

// File: rtl/tb_service_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, occupancy counter one bit wider than the pointers.
// A push while full succeeds only when a pop happens in the same cycle.
module tb_service_cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     cptra_rst_b,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;

    // Storage, wrapping pointers and occupancy.
    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tb_service_cmd_dispatch.sv
// Dispatches TB service commands written to SERVICE_ADDR as one-cycle pulses, spaced by a gap or long hold.
// Optional build macro TB_SERVICE_CMD_TRACE_EN prints each dispatch and each dropped command.
module tb_service_cmd_dispatch
    import tb_service_pkg::*;
#(
    parameter logic [31:0] SERVICE_ADDR = SERVICE_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          MIN_GAP      = 2,
    parameter logic [7:0]  LONG_CMD     = LONG_CMD_VALUE,
    parameter int          LONG_HOLD    = 12
) (
    input  logic                      clk,
    input  logic                      cptra_rst_b,
    tb_service_cmd_dispatch_if.slave  wr,
    output logic                      tb_service_cmd_valid,
    output logic [7:0]                tb_service_cmd,
    output logic                      busy,
    output logic                      overflow,
    output logic [15:0]               dispatch_cnt
);
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] GAP_LOAD  = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'h00;
    localparam logic [7:0] HOLD_LOAD = 8'(LONG_HOLD - 1);

    state_e        state_r;
    state_e        state_s;
    logic [7:0]    tmr_r;
    logic [7:0]    tmr_s;
    logic          valid_r;
    logic [7:0]    cmd_r;
    logic [15:0]   cnt_r;
    logic          ovf_r;
    logic          busy_r;

    logic          push_s;
    logic          push_ok_s;
    logic          pop_s;
    logic          drop_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_nx_s;
    logic [7:0]    head_s;
    logic          unused_data_s;

    assign unused_data_s = ^wr.wr_data[31:8];
    assign push_s        = is_service_write(wr.wr_valid, wr.wr_addr, wr.wr_data, SERVICE_ADDR);
    assign push_ok_s     = push_s && (!full_s || pop_s);
    assign drop_s        = push_s && full_s && !pop_s;
    assign count_nx_s    = count_s + CW'(push_ok_s) - CW'(pop_s);

    tb_service_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .cptra_rst_b (cptra_rst_b),
        .push        (push_s),
        .push_data   (wr.wr_data[7:0]),
        .pop         (pop_s),
        .pop_data    (head_s),
        .full        (full_s),
        .empty       (empty_s),
        .count       (count_s)
    );

    // Next-state logic; the pop is issued on the transition into ISSUE so the pulse appears a cycle later.
    always_comb begin
        state_s = state_r;
        tmr_s   = tmr_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_s = ST_ISSUE;
                    pop_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_r == LONG_CMD) begin
                    state_s = ST_HOLD;
                    tmr_s   = HOLD_LOAD;
                end else if (MIN_GAP > 0) begin
                    state_s = ST_GAP;
                    tmr_s   = GAP_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            // The last gap cycle issues directly so back-to-back commands sit MIN_GAP idle cycles apart.
            ST_GAP: begin
                if (tmr_r != 8'h00) begin
                    tmr_s = tmr_r - 8'h01;
                end else if (!empty_s) begin
                    state_s = ST_ISSUE;
                    pop_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (tmr_r != 8'h00) begin
                    tmr_s = tmr_r - 8'h01;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                tmr_s   = 8'h00;
            end
        endcase
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state_r <= ST_IDLE;
            tmr_r   <= 8'h00;
            valid_r <= 1'b0;
            cmd_r   <= 8'h00;
            cnt_r   <= 16'h0000;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tmr_r   <= tmr_s;
            valid_r <= pop_s;
            cmd_r   <= pop_s ? head_s : 8'h00;
            cnt_r   <= pop_s ? (cnt_r + 16'h0001) : cnt_r;
            ovf_r   <= ovf_r || drop_s;
            busy_r  <= (count_nx_s != {CW{1'b0}}) || (state_s != ST_IDLE);
        end
    end

    assign tb_service_cmd_valid = valid_r;
    assign tb_service_cmd       = cmd_r;
    assign busy                 = busy_r;
    assign overflow             = ovf_r;
    assign dispatch_cnt         = cnt_r;

`ifdef TB_SERVICE_CMD_TRACE_EN
    // Simulation trace of dispatches and drops.
    always_ff @(posedge clk) begin
        if (valid_r) begin
            $display("tb_service_cmd_dispatch: cmd=0x%02h cnt=%0d", cmd_r, cnt_r);
        end
        if (cptra_rst_b && drop_s) begin
            $display("overflow");
        end
    end
`else
    // Tracing compiled out; cycle behaviour is unchanged.
`endif

endmodule
